// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default frame
// geometry used by the transmitter, receiver and baud-rate generator.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam int unsigned UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module uart_sync2 #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic Clock,
    input  logic ResetN,
    input  logic asyncIn,
    output logic syncOut
);

    logic meta;

    // Two back-to-back flops; both preset to the line's idle level.
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            meta    <= RESET_VALUE;
            syncOut <= RESET_VALUE;
        end else begin
            meta    <= asyncIn;
            syncOut <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: 8N1-style framing, LSB first, mid-bit sampling on the
// oversample strobe, one-entry output register with valid/ack handshake.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = UART_DATA_BITS,
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 Clock,
    input  logic                 ResetN,
    input  logic                 Tick,
    input  logic                 Rx,
    input  logic                 RxAck,
    output logic [DATA_BITS-1:0] DataOut,
    output logic                 RxValid,
    output logic                 FrameError,
    output logic                 Overrun
);

    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

    logic                 rxS;
    rx_state_t            stateQ, stateD;
    logic [TICK_W-1:0]    tickQ, tickD;
    logic [2:0]           bitQ, bitD;
    logic [DATA_BITS-1:0] shiftQ, shiftD;
    logic [DATA_BITS-1:0] dataD;
    logic                 validD, frameErrD, overrunD, deliver;

    uart_sync2 #(
        .RESET_VALUE(1'b1)
    ) u_rx_sync (
        .Clock  (Clock),
        .ResetN (ResetN),
        .asyncIn(Rx),
        .syncOut(rxS)
    );

    // State, counters, shift register and output register.
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            stateQ     <= IDLE;
            tickQ      <= '0;
            bitQ       <= '0;
            shiftQ     <= '0;
            DataOut    <= '0;
            RxValid    <= 1'b0;
            FrameError <= 1'b0;
            Overrun    <= 1'b0;
        end else begin
            stateQ     <= stateD;
            tickQ      <= tickD;
            bitQ       <= bitD;
            shiftQ     <= shiftD;
            DataOut    <= dataD;
            RxValid    <= validD;
            FrameError <= frameErrD;
            Overrun    <= overrunD;
        end
    end

    // Frame sequencing, sampling and host handshake.
    always_comb begin
        stateD    = stateQ;
        tickD     = tickQ;
        bitD      = bitQ;
        shiftD    = shiftQ;
        dataD     = DataOut;
        validD    = RxValid;
        frameErrD = 1'b0;
        overrunD  = 1'b0;
        deliver   = 1'b0;

        case (stateQ)
            IDLE: begin
                if (!rxS) begin
                    stateD = START;
                    tickD  = '0;
                end
            end
            START: begin
                if (Tick) begin
                    if (tickQ == HALF_LAST) begin
                        // Still low at mid start bit: genuine frame, else a glitch.
                        if (!rxS) begin
                            stateD = DATA;
                            tickD  = '0;
                            bitD   = '0;
                        end else begin
                            stateD = IDLE;
                        end
                    end else begin
                        tickD = tickQ + 1'b1;
                    end
                end
            end
            DATA: begin
                if (Tick) begin
                    if (tickQ == FULL_LAST) begin
                        // LSB arrives first, so shifting right leaves it at bit 0.
                        shiftD = (shiftQ >> 1) | (DATA_BITS'(rxS) << (DATA_BITS - 1));
                        tickD  = '0;
                        if (bitQ == BIT_LAST) begin
                            stateD = STOP;
                        end else begin
                            bitD = bitQ + 1'b1;
                        end
                    end else begin
                        tickD = tickQ + 1'b1;
                    end
                end
            end
            STOP: begin
                if (Tick) begin
                    if (tickQ == FULL_LAST) begin
                        tickD = '0;
                        if (rxS) begin
                            deliver = 1'b1;
                            stateD  = IDLE;
                        end else begin
                            frameErrD = 1'b1;
                            stateD    = BREAK;
                        end
                    end else begin
                        tickD = tickQ + 1'b1;
                    end
                end
            end
            BREAK: begin
                // A held-low line must return high before a new start is accepted.
                if (rxS) begin
                    stateD = IDLE;
                end
            end
            default: begin
                stateD = IDLE;
            end
        endcase

        if (deliver) begin
            dataD    = shiftQ;
            validD   = 1'b1;
            overrunD = RxValid && !RxAck;
        end else if (RxValid && RxAck) begin
            validD = 1'b0;
        end
    end

endmodule
